// File: rtl/int_bit_pkg.sv
// int_bit_pkg: shared defaults, scan FSM states and the single-bit-remaining check.
package int_bit_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_IDX_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  // Zero-extending to 64 bits keeps x & (x-1) exact for any WIDTH up to 64.
  function automatic logic one_left(input logic [63:0] x);
    return (x & (x - 64'd1)) == 64'd0;
  endfunction
endpackage

// File: rtl/int_lsb_enc.sv
// int_lsb_enc: index of the lowest set bit of a vector, plus an any-bit-set flag.
module int_lsb_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_W'(i);
  end
  assign any = |vec;
endmodule

// File: rtl/int_bit_scan.sv
// int_bit_scan: streams the index of every set bit of a word, LSB first, then pulses done with the count.
module int_bit_scan
  import int_bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic [IDX_W:0]   count
);
  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [IDX_W:0]   cnt;
  logic [IDX_W-1:0] low_idx;
  logic             any;
  int_lsb_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .vec(shadow),
    .idx(low_idx),
    .any(any)
  );
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_SCAN;
  assign out_index = out_valid ? low_idx : '0;
  assign out_last  = out_valid && any && one_left(64'(shadow));
  assign done      = state == ST_DONE;
  assign count     = done ? cnt : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      shadow <= '0;
      cnt    <= '0;
    end else if (abort && state != ST_IDLE) begin
      state  <= ST_IDLE;
      shadow <= '0;
      cnt    <= '0;
    end else if (state == ST_IDLE) begin
      if (in_valid) begin
        shadow <= in_word;
        cnt    <= '0;
        state  <= |in_word ? ST_SCAN : ST_DONE;
      end
    end else if (state == ST_SCAN) begin
      if (out_ready) begin
        shadow <= shadow & ~(WIDTH'(1) << out_index);
        cnt    <= cnt + 1'b1;
        if (out_last) state <= ST_DONE;
      end
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule
